mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/constants.sv | 19 +
 rtl/register.sv | 27 ++
 rtl/wait_counter.sv | 28 ++
 rtl/mem_bus_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/constants.sv
// Shared types and constants for mem_bus_arbiter: the arbiter state
// encoding, bus-owner encoding and datapath/counter widths.
package mem_bus_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;   // covers WAIT_STATES up to 15

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DMA_ACC = 2'd2
    } arbState_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/register.sv
// Generic clearable load register; holds the granted requester's
// address and write data for the duration of a memory access.
module register #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Clear wins over load so the bus returns to zero between accesses.
    always_ff @(posedge clock) begin
        if (!reset_L || i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/wait_counter.sv
// Wait-state counter: counts 0..WAIT_STATES-1 while enabled and flags
// the terminal count, which marks the completion cycle of an access.
module wait_counter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic clock,
    input  logic reset_L,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CNT_W-1:0] r_count;

    // Clear has priority; the owner clears on terminal count and in IDLE.
    always_ff @(posedge clock) begin
        if (!reset_L || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == CNT_W'(WAIT_STATES - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the CPU and a DMA/debug
// requester. Each access holds its strobe low for WAIT_STATES cycles and
// is followed by a one-cycle IDLE bubble.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate ownership on
// contention; the default build gives the CPU fixed priority.
//
// Handshake: the CPU holds cpu_re_L/cpu_we_L low and keeps its state while
// cpu_stall is high; the cycle with the request still asserted and
// cpu_stall low is the completion cycle, and cpu_rdata is valid in it.
// The DMA raises dma_req and holds it until dma_gnt is seen; dma_done
// pulses for one cycle after completion, and dma_req must drop in that
// cycle or the DMA re-arbitrates.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset_L,
    input  logic        cpu_re_L,
    input  logic        cpu_we_L,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_done,
    output logic [15:0] dma_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_re_L,
    output logic        mem_we_L,
    input  logic [15:0] mem_rdata,
    output logic        owner,
    output arbState_t   dbg_state
);

    arbState_t          r_state;
    owner_t             r_owner;
    logic               r_mem_re_L;
    logic               r_mem_we_L;
    logic               r_dma_gnt;
    logic               r_dma_done;
    logic [DATA_W-1:0]  r_dma_rdata;

    logic               w_cpu_req;
    logic               w_cpu_we;
    logic               w_active;
    logic               w_tc;
    logic               w_done;
    logic               w_pick_cpu;
    logic               w_pick_dma;
    logic               w_grant;
    logic [DATA_W-1:0]  w_addr_d;
    logic [DATA_W-1:0]  w_wdata_d;
    logic [DATA_W-1:0]  w_lat_addr;
    logic [DATA_W-1:0]  w_lat_wdata;

    // A write wins when the CPU drives both strobes low.
    assign w_cpu_req = !cpu_re_L || !cpu_we_L;
    assign w_cpu_we  = !cpu_we_L;
    assign w_active  = (r_state != IDLE);
    assign w_done    = w_active && w_tc;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t r_last_owner;

    // Remember who owned the last completed access; DMA after reset so
    // the CPU wins the first contention.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            r_last_owner <= OWN_DMA;
        end else if (w_done) begin
            r_last_owner <= r_owner;
        end
    end
`endif

    // Arbitration, evaluated only in IDLE.
    always_comb begin
        w_pick_cpu = 1'b0;
        w_pick_dma = 1'b0;
        if (r_state == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (w_cpu_req && dma_req) begin
                w_pick_cpu = (r_last_owner == OWN_DMA);
                w_pick_dma = (r_last_owner == OWN_CPU);
            end else begin
                w_pick_cpu = w_cpu_req;
                w_pick_dma = dma_req;
            end
`else
            w_pick_cpu = w_cpu_req;
            w_pick_dma = dma_req && !w_cpu_req;
`endif
        end
    end

    assign w_grant   = w_pick_cpu || w_pick_dma;
    assign w_addr_d  = w_pick_cpu ? cpu_addr  : dma_addr;
    assign w_wdata_d = w_pick_cpu ? cpu_wdata : dma_wdata;

    register #(.WIDTH(DATA_W)) u_addr_lat (
        .clock   (clock),
        .reset_L (reset_L),
        .i_clr   (w_done),
        .i_load  (w_grant),
        .i_d     (w_addr_d),
        .o_q     (w_lat_addr)
    );

    register #(.WIDTH(DATA_W)) u_wdata_lat (
        .clock   (clock),
        .reset_L (reset_L),
        .i_clr   (w_done),
        .i_load  (w_grant),
        .i_d     (w_wdata_d),
        .o_q     (w_lat_wdata)
    );

    wait_counter #(.WAIT_STATES(WAIT_STATES)) u_wait (
        .clock   (clock),
        .reset_L (reset_L),
        .i_clr   (!w_active || w_tc),
        .i_en    (w_active),
        .o_tc    (w_tc)
    );

    // Arbiter FSM: grant from IDLE, hold strobe until terminal count,
    // always return to IDLE. Direction is latched into the strobes.
    always_ff @(posedge clock) begin
        if (!reset_L) begin
            r_state     <= IDLE;
            r_owner     <= OWN_CPU;
            r_mem_re_L  <= 1'b1;
            r_mem_we_L  <= 1'b1;
            r_dma_gnt   <= 1'b0;
            r_dma_done  <= 1'b0;
            r_dma_rdata <= '0;
        end else begin
            r_dma_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_cpu) begin
                        r_state    <= CPU_ACC;
                        r_owner    <= OWN_CPU;
                        r_mem_re_L <= w_cpu_we;
                        r_mem_we_L <= !w_cpu_we;
                    end else if (w_pick_dma) begin
                        r_state    <= DMA_ACC;
                        r_owner    <= OWN_DMA;
                        r_dma_gnt  <= 1'b1;
                        r_mem_re_L <= dma_we;
                        r_mem_we_L <= !dma_we;
                    end
                end
                CPU_ACC: begin
                    if (w_tc) begin
                        r_state    <= IDLE;
                        r_owner    <= OWN_CPU;
                        r_mem_re_L <= 1'b1;
                        r_mem_we_L <= 1'b1;
                    end
                end
                DMA_ACC: begin
                    if (w_tc) begin
                        r_state    <= IDLE;
                        r_owner    <= OWN_CPU;
                        r_mem_re_L <= 1'b1;
                        r_mem_we_L <= 1'b1;
                        r_dma_gnt  <= 1'b0;
                        r_dma_done <= 1'b1;
                        if (!r_mem_re_L) begin
                            r_dma_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_owner    <= OWN_CPU;
                    r_mem_re_L <= 1'b1;
                    r_mem_we_L <= 1'b1;
                    r_dma_gnt  <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_rdata = mem_rdata;
    assign cpu_stall = w_cpu_req && !((r_state == CPU_ACC) && w_tc);
    assign dma_gnt   = r_dma_gnt;
    assign dma_done  = r_dma_done;
    assign dma_rdata = r_dma_rdata;
    assign mem_addr  = w_lat_addr;
    assign mem_wdata = w_lat_wdata;
    assign mem_re_L  = r_mem_re_L;
    assign mem_we_L  = r_mem_we_L;
    assign owner     = r_owner;
    assign dbg_state = r_state;

endmodule
